// File: rtl/or_fr_monitor.sv
// Checks a == b | c on an OR DUT; counts errors, flags a forced (stuck) output and its release.
// Define ORMON_FIRST_ERR_EN to capture {b,c,a} of the first mismatch.
module or_fr_monitor #(
  parameter int WIDTH       = 2,
  parameter int STUCK_LIMIT = 4,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [WIDTH-1:0]   in_c,
  input  logic [WIDTH-1:0]   out_a,
  output logic               mismatch,
  output logic               stuck,
  output logic               released,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   chk_cnt,
  output logic [1:0]         state,
  output logic [3*WIDTH-1:0] first_err,
  output logic               first_err_vld
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    CHECK  = 2'd2,
    FORCED = 2'd3
  } state_e;

  localparam logic [7:0]       LIMIT = 8'(STUCK_LIMIT);
  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [CNT_W-1:0] CONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] s_b_q, s_b_d;
  logic [WIDTH-1:0] s_c_q, s_c_d;
  logic [WIDTH-1:0] s_a_q, s_a_d;
  logic [7:0]       run_q, run_d;
  logic             stuck_q, stuck_d;
  logic             mism_q, mism_d;
  logic             rel_q, rel_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] chk_q, chk_d;
  logic             do_chk;
  logic             miss;
  logic             run_hit;

  assign do_chk  = en && (state_q == CHECK || state_q == FORCED);
  assign miss    = s_a_q != (s_b_q | s_c_q);
  assign run_hit = run_q >= (LIMIT - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = en ? FILL : IDLE;
    end else if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = FILL;
        FILL:    state_d = CHECK;
        CHECK:   if (miss && run_hit) state_d = FORCED;
        FORCED:  if (!miss) state_d = CHECK;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    s_b_d   = en ? in_b  : s_b_q;
    s_c_d   = en ? in_c  : s_c_q;
    s_a_d   = en ? out_a : s_a_q;
    run_d   = run_q;
    stuck_d = stuck_q;
    mism_d  = 1'b0;
    rel_d   = 1'b0;
    err_d   = err_q;
    chk_d   = chk_q;
    if (clr) begin
      run_d   = '0;
      stuck_d = 1'b0;
      err_d   = '0;
      chk_d   = '0;
    end else if (!en) begin
      run_d = '0;
    end else if (do_chk) begin
      chk_d = (chk_q == CMAX) ? chk_q : chk_q + CONE;
      if (miss) begin
        mism_d = 1'b1;
        err_d  = (err_q == CMAX) ? err_q : err_q + CONE;
        run_d  = run_hit ? LIMIT : run_q + 8'd1;
        if (state_q == CHECK && run_hit) stuck_d = 1'b1;
      end else begin
        run_d = '0;
        if (state_q == FORCED) begin
          rel_d   = 1'b1;
          stuck_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_b_q   <= '0;
      s_c_q   <= '0;
      s_a_q   <= '0;
      run_q   <= '0;
      stuck_q <= 1'b0;
      mism_q  <= 1'b0;
      rel_q   <= 1'b0;
      err_q   <= '0;
      chk_q   <= '0;
    end else begin
      s_b_q   <= s_b_d;
      s_c_q   <= s_c_d;
      s_a_q   <= s_a_d;
      run_q   <= run_d;
      stuck_q <= stuck_d;
      mism_q  <= mism_d;
      rel_q   <= rel_d;
      err_q   <= err_d;
      chk_q   <= chk_d;
    end
  end

  assign mismatch = mism_q;
  assign released = rel_q;
  assign stuck    = stuck_q;
  assign err_cnt  = err_q;
  assign chk_cnt  = chk_q;
  assign state    = state_q;

`ifdef ORMON_FIRST_ERR_EN
  logic [3*WIDTH-1:0] fe_q, fe_d;
  logic               fe_vld_q, fe_vld_d;

  always_comb begin
    fe_d     = fe_q;
    fe_vld_d = fe_vld_q;
    if (clr) begin
      fe_d     = '0;
      fe_vld_d = 1'b0;
    end else if (do_chk && miss && !fe_vld_q) begin
      fe_d     = {s_b_q, s_c_q, s_a_q};
      fe_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fe_q     <= '0;
      fe_vld_q <= 1'b0;
    end else begin
      fe_q     <= fe_d;
      fe_vld_q <= fe_vld_d;
    end
  end

  assign first_err     = fe_q;
  assign first_err_vld = fe_vld_q;
`else
  assign first_err     = '0;
  assign first_err_vld = 1'b0;
`endif

endmodule

// File: tb/tb_or_fr_monitor.sv
// Bench for or_fr_monitor: vector table, directed corner cases and
// randomized traffic against a behavioural model.
module tb_or_fr_monitor;

  localparam int LIM = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, clr;
  logic [1:0] in_b, in_c, out_a;

  logic       mismatch, stuck, released, first_err_vld;
  logic [7:0] err_cnt, chk_cnt;
  logic [1:0] state;
  logic [5:0] first_err;

  logic       s_mismatch, s_stuck, s_released, s_first_err_vld;
  logic [3:0] s_err_cnt, s_chk_cnt;
  logic [1:0] s_state;
  logic [5:0] s_first_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  or_fr_monitor #(.WIDTH(2), .STUCK_LIMIT(LIM), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .in_b(in_b), .in_c(in_c), .out_a(out_a),
    .mismatch(mismatch), .stuck(stuck), .released(released),
    .err_cnt(err_cnt), .chk_cnt(chk_cnt), .state(state),
    .first_err(first_err), .first_err_vld(first_err_vld)
  );

  or_fr_monitor #(.WIDTH(2), .STUCK_LIMIT(LIM), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .in_b(in_b), .in_c(in_c), .out_a(out_a),
    .mismatch(s_mismatch), .stuck(s_stuck), .released(s_released),
    .err_cnt(s_err_cnt), .chk_cnt(s_chk_cnt), .state(s_state),
    .first_err(s_first_err), .first_err_vld(s_first_err_vld)
  );

  // behavioural reference
  int         m_phase, m_run, m_err, m_chk;
  bit         m_stuck, m_mism, m_rel, m_fev;
  logic [5:0] m_fe;
  logic [1:0] pb, pc, pa;

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_err = 0; m_chk = 0;
    m_stuck = 0; m_mism = 0; m_rel = 0; m_fev = 0; m_fe = '0;
    pb = '0; pc = '0; pa = '0;
  endtask

  task automatic model_step(bit e, bit c, logic [1:0] b, logic [1:0] cc,
                            logic [1:0] a);
    bit miss;
    miss = pa != (pb | pc);
    m_mism = 0;
    m_rel  = 0;
    if (c) begin
      m_err = 0; m_chk = 0; m_run = 0; m_stuck = 0; m_fev = 0; m_fe = '0;
      m_phase = e ? 1 : 0;
    end else if (!e) begin
      m_phase = 0;
      m_run   = 0;
    end else if (m_phase < 2) begin
      m_phase++;
    end else begin
      m_chk++;
      if (miss) begin
        m_err++;
        m_mism = 1;
`ifdef ORMON_FIRST_ERR_EN
        if (!m_fev) begin m_fev = 1; m_fe = {pb, pc, pa}; end
`endif
        if (m_phase == 2) begin
          m_run++;
          if (m_run >= LIM) begin m_phase = 3; m_stuck = 1; end
        end
      end else begin
        m_run = 0;
        if (m_phase == 3) begin m_phase = 2; m_rel = 1; m_stuck = 0; end
      end
    end
    if (e) begin pb = b; pc = cc; pa = a; end
  endtask

  task automatic cmp(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(bit e, bit c, logic [1:0] b, logic [1:0] cc,
                     logic [1:0] a);
    en = e; clr = c; in_b = b; in_c = cc; out_a = a;
    @(posedge clk);
    model_step(e, c, b, cc, a);
    #1;
  endtask

  task automatic check_model();
    cmp("m_mismatch", mismatch, m_mism);
    cmp("m_released", released, m_rel);
    cmp("m_stuck", stuck, m_stuck);
    cmp("m_state", state, m_phase);
    cmp("m_err_cnt", err_cnt, sat(m_err, 255));
    cmp("m_chk_cnt", chk_cnt, sat(m_chk, 255));
    cmp("m_err_cnt_w4", s_err_cnt, sat(m_err, 15));
    cmp("m_chk_cnt_w4", s_chk_cnt, sat(m_chk, 15));
    cmp("m_first_err_vld", first_err_vld, m_fev);
    cmp("m_first_err", first_err, m_fe);
  endtask

  task automatic do_reset();
    en = 0; clr = 0; in_b = '0; in_c = '0; out_a = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit         en;
    bit         clr;
    logic [1:0] b, c, a;
    bit         mism, rel, stk;
    int         st, err, chk;
  } vec_t;

  vec_t tbl[15];
  int   pulses;
  bit   saw_m, saw_s;
  int   f_left;
  logic [1:0] f_val, rb, rc, ra;

  initial begin
    tbl[0]  = '{1, 0, 0, 3, 3, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 0, 3, 3, 0, 0, 0, 2, 0, 0};
    tbl[2]  = '{1, 0, 0, 3, 0, 0, 0, 0, 2, 0, 1};
    tbl[3]  = '{1, 0, 0, 3, 0, 1, 0, 0, 2, 1, 2};
    tbl[4]  = '{1, 0, 0, 3, 0, 1, 0, 0, 2, 2, 3};
    tbl[5]  = '{1, 0, 0, 3, 0, 1, 0, 0, 2, 3, 4};
    tbl[6]  = '{1, 0, 0, 3, 0, 1, 0, 1, 3, 4, 5};
    tbl[7]  = '{1, 0, 0, 3, 0, 1, 0, 1, 3, 5, 6};
    tbl[8]  = '{1, 0, 0, 3, 3, 1, 0, 1, 3, 6, 7};
    tbl[9]  = '{1, 0, 0, 3, 3, 0, 1, 0, 2, 6, 8};
    tbl[10] = '{1, 0, 0, 3, 0, 0, 0, 0, 2, 6, 9};
    tbl[11] = '{1, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0};
    tbl[12] = '{1, 0, 0, 3, 3, 0, 0, 0, 2, 0, 0};
    tbl[13] = '{1, 0, 0, 3, 3, 0, 0, 0, 2, 0, 1};
    tbl[14] = '{0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1};

    do_reset();
    cmp("rst_state", state, 0);
    cmp("rst_stuck", stuck, 0);
    cmp("rst_mismatch", mismatch, 0);
    cmp("rst_err_cnt", err_cnt, 0);
    cmp("rst_chk_cnt", chk_cnt, 0);
    cmp("rst_first_err_vld", first_err_vld, 0);

    // stuck onset, release and clear priority
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].en, tbl[i].clr, tbl[i].b, tbl[i].c, tbl[i].a);
      cmp($sformatf("tbl%0d_mismatch", i), mismatch, tbl[i].mism);
      cmp($sformatf("tbl%0d_released", i), released, tbl[i].rel);
      cmp($sformatf("tbl%0d_stuck", i), stuck, tbl[i].stk);
      cmp($sformatf("tbl%0d_state", i), state, tbl[i].st);
      cmp($sformatf("tbl%0d_err_cnt", i), err_cnt, tbl[i].err);
      cmp($sformatf("tbl%0d_chk_cnt", i), chk_cnt, tbl[i].chk);
    end
    cmp("clr_no_capture", first_err_vld, 0);

    // clean run: 2 fill edges then 20 checks
    do_reset();
    saw_m = 0; saw_s = 0;
    for (int i = 0; i < 22; i++) begin
      cyc(1, 0, 2'b00, (i % 2) ? 2'b11 : 2'b00, (i % 2) ? 2'b11 : 2'b00);
      saw_m |= mismatch;
      saw_s |= stuck;
    end
    cmp("clean_chk_cnt", chk_cnt, 20);
    cmp("clean_err_cnt", err_cnt, 0);
    cmp("clean_chk_cnt_w4", s_chk_cnt, 15);
    cmp("clean_mismatch_seen", saw_m, 0);
    cmp("clean_stuck_seen", saw_s, 0);

    // a forced to 00 for 6 cycles while c toggles
    pulses = 0; saw_s = 0;
    for (int i = 0; i < 8; i++) begin
      rc = (i % 2) ? 2'b11 : 2'b00;
      cyc(1, 0, 2'b00, rc, (i < 6) ? 2'b00 : rc);
      pulses += int'(mismatch);
      saw_s |= stuck;
    end
    cmp("toggle_pulses", pulses, 3);
    cmp("toggle_err_cnt", err_cnt, 3);
    cmp("toggle_stuck_seen", saw_s, 0);

    // saturation with 20 consecutive mismatches
    do_reset();
    for (int i = 0; i < 22; i++) cyc(1, 0, 2'b00, 2'b11, 2'b00);
    cmp("sat_err_cnt_w4", s_err_cnt, 15);
    cmp("sat_chk_cnt_w4", s_chk_cnt, 15);
    cmp("sat_err_cnt_w8", err_cnt, 20);
    cmp("sat_state", state, 3);

    // async reset between edges while FORCED
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    cmp("arst_stuck", stuck, 0);
    cmp("arst_state", state, 0);
    cmp("arst_err_cnt", err_cnt, 0);
    cmp("arst_chk_cnt", chk_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 2'b00, 2'b11, 2'b00);
      check_model();
    end

    // first-error capture
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 0, 2'b01, 2'b10, 2'b01);
    for (int i = 0; i < 2; i++) cyc(1, 0, 2'b01, 2'b10, 2'b00);
`ifdef ORMON_FIRST_ERR_EN
    cmp("fe_value", first_err, 6'b01_10_01);
    cmp("fe_vld", first_err_vld, 1);
`else
    cmp("fe_value_off", first_err, 0);
    cmp("fe_vld_off", first_err_vld, 0);
`endif
    check_model();

    // randomized traffic against the model
    do_reset();
    f_left = 0; f_val = '0;
    for (int i = 0; i < 800; i++) begin
      rb = 2'($urandom);
      rc = 2'($urandom);
      if (f_left == 0 && $urandom_range(0, 9) == 0) begin
        f_left = $urandom_range(1, 9);
        f_val  = 2'($urandom);
      end
      if (f_left > 0) begin
        ra = f_val;
        f_left--;
      end else begin
        ra = rb | rc;
      end
      cyc($urandom_range(0, 19) != 0, $urandom_range(0, 39) == 0, rb, rc, ra);
      check_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
